rps_referee: RTL

// Rock-paper-scissors match referee: core DUT driven by the team's clk/rst generator.
// - Accepts one move per round from each of two players over valid/ready handshakes.
// - Judges each round, reports the result over a valid/ready handshake, keeps running scores.
// - Declares the match over when either player reaches WIN_COUNT round wins.
//

---
 rtl/rps_referee_if.sv | 40 ++++
 rtl/rps_referee.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_referee_if.sv
// ----------------------------------------------------------------------------
// rps_referee_if
//
// Purpose:
//   Groups the three valid/ready channels of the rock-paper-scissors referee:
//   one move channel per player and one round-result channel.
//
// Signals:
//   p1_valid / p1_move / p1_ready   player 1 move channel (move: 01 rock,
//                                   10 paper, 11 scissors, 00 illegal)
//   p2_valid / p2_move / p2_ready   player 2 move channel, same encoding
//   res_valid / res_winner / res_ready
//                                   round result channel (winner: 00 draw,
//                                   01 player 1, 10 player 2)
//
// Modports:
//   master  the environment: offers moves, consumes results
//   slave   the referee: accepts moves, produces results
// ----------------------------------------------------------------------------
interface rps_referee_if;
    logic       p1_valid;
    logic [1:0] p1_move;
    logic       p1_ready;
    logic       p2_valid;
    logic [1:0] p2_move;
    logic       p2_ready;
    logic       res_valid;
    logic [1:0] res_winner;
    logic       res_ready;

    modport master (
        output p1_valid, p1_move, p2_valid, p2_move, res_ready,
        input  p1_ready, p2_ready, res_valid, res_winner
    );

    modport slave (
        input  p1_valid, p1_move, p2_valid, p2_move, res_ready,
        output p1_ready, p2_ready, res_valid, res_winner
    );
endinterface

// File: rtl/rps_referee.sv
// ----------------------------------------------------------------------------
// rps_referee
//
// Purpose:
//   Referee for a rock-paper-scissors match between two players. Each round
//   it collects one move per player, judges the round, reports the result
//   over a valid/ready handshake and keeps running scores. The match ends
//   when either player reaches WIN_COUNT round wins; the referee then holds
//   the final result until a synchronous clear starts a new match.
//
// Parameters:
//   WIN_COUNT  round wins needed to take the match (1 .. 2**SCORE_W-1)
//   SCORE_W    width of each score counter
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   clear         synchronous new-match request, highest priority
//   bus           rps_referee_if.slave: both move channels + result channel
//   p1_score      player 1 round wins this match
//   p2_score      player 2 round wins this match
//   match_over    a player has reached WIN_COUNT
//   match_winner  01 player 1, 10 player 2, 00 while the match is running
//   draw_count    (RPS_DRAW_COUNT_EN only) saturating count of drawn rounds
//
// Build option:
//   RPS_DRAW_COUNT_EN  when defined, adds the draw_count output and counter.
//
// Timing:
//   Last move accepted in cycle N -> JUDGE in N+1 -> res_valid high in N+2.
//   With res_ready already high the next move can be accepted in N+3.
// ----------------------------------------------------------------------------
module rps_referee #(
    parameter int WIN_COUNT = 3,
    parameter int SCORE_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    rps_referee_if.slave        bus,
    output logic [SCORE_W-1:0]  p1_score,
    output logic [SCORE_W-1:0]  p2_score,
    output logic                match_over,
    output logic [1:0]          match_winner
`ifdef RPS_DRAW_COUNT_EN
    ,
    output logic [SCORE_W-1:0]  draw_count
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------------
    if ((WIN_COUNT < 1) || (WIN_COUNT > (2 ** SCORE_W) - 1)) begin : g_win_count_check
        $error("rps_referee: WIN_COUNT must be in 1 .. 2**SCORE_W-1");
    end

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] MOVE_ILLEGAL  = 2'b00;
    localparam logic [1:0] MOVE_ROCK     = 2'b01;
    localparam logic [1:0] MOVE_PAPER    = 2'b10;
    localparam logic [1:0] MOVE_SCISSORS = 2'b11;

    localparam logic [1:0] RES_DRAW = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_COUNT);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,   // waiting for one or both moves
        S_JUDGE   = 2'd1,   // one cycle: decide round, bump score
        S_REPORT  = 2'd2,   // result offered until consumer takes it
        S_DONE    = 2'd3    // match decided, waiting for clear
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               state_q;
    logic                 p1_have_q;
    logic                 p2_have_q;
    logic [1:0]           p1_move_q;
    logic [1:0]           p2_move_q;
    logic [SCORE_W-1:0]   p1_score_q;
    logic [SCORE_W-1:0]   p2_score_q;
    logic                 res_valid_q;
    logic [1:0]           res_winner_q;
    logic                 match_over_q;
    logic [1:0]           match_winner_q;

    // ------------------------------------------------------------------------
    // Round judgement
    // A single illegal move forfeits the round to the opponent; two illegal
    // moves are treated like two equal moves (draw).
    // ------------------------------------------------------------------------
    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] w;
        w = RES_DRAW;
        if ((a == MOVE_ILLEGAL) && (b == MOVE_ILLEGAL)) begin
            w = RES_DRAW;
        end else if (a == MOVE_ILLEGAL) begin
            w = RES_P2;
        end else if (b == MOVE_ILLEGAL) begin
            w = RES_P1;
        end else if (a == b) begin
            w = RES_DRAW;
        end else if (((a == MOVE_PAPER)    && (b == MOVE_ROCK))     ||
                     ((a == MOVE_ROCK)     && (b == MOVE_SCISSORS)) ||
                     ((a == MOVE_SCISSORS) && (b == MOVE_PAPER))) begin
            w = RES_P1;
        end else begin
            w = RES_P2;
        end
        return w;
    endfunction

    logic [1:0]         round_winner;
    logic [SCORE_W-1:0] p1_score_d;
    logic [SCORE_W-1:0] p2_score_d;

    assign round_winner = judge(p1_move_q, p2_move_q);

    // Scores can only be incremented in JUDGE, and JUDGE is never reached
    // once a score equals WIN_VAL, so the +1 can never wrap.
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        if (round_winner == RES_P1) begin
            p1_score_d = p1_score_q + 1'b1;
        end else if (round_winner == RES_P2) begin
            p2_score_d = p2_score_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Move acceptance
    // Readys are held low during reset and during a clear cycle so a move
    // offered then is never silently consumed.
    // ------------------------------------------------------------------------
    logic collect_open;
    logic p1_take;
    logic p2_take;

    assign collect_open = (state_q == S_COLLECT) && !clear && !rst;
    assign bus.p1_ready = collect_open && !p1_have_q;
    assign bus.p2_ready = collect_open && !p2_have_q;
    assign p1_take      = bus.p1_valid && bus.p1_ready;
    assign p2_take      = bus.p2_valid && bus.p2_ready;

    // ------------------------------------------------------------------------
    // Main FSM with registered result / match outputs
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from the values sampled at the clock edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_COLLECT;
            p1_have_q      <= 1'b0;
            p2_have_q      <= 1'b0;
            p1_move_q      <= MOVE_ILLEGAL;
            p2_move_q      <= MOVE_ILLEGAL;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            res_valid_q    <= 1'b0;
            res_winner_q   <= RES_DRAW;
            match_over_q   <= 1'b0;
            match_winner_q <= RES_DRAW;
        end else if (clear) begin
            state_q        <= S_COLLECT;
            p1_have_q      <= 1'b0;
            p2_have_q      <= 1'b0;
            p1_move_q      <= MOVE_ILLEGAL;
            p2_move_q      <= MOVE_ILLEGAL;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            res_valid_q    <= 1'b0;
            res_winner_q   <= RES_DRAW;
            match_over_q   <= 1'b0;
            match_winner_q <= RES_DRAW;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (p1_take) begin
                        p1_move_q <= bus.p1_move;
                        p1_have_q <= 1'b1;
                    end
                    if (p2_take) begin
                        p2_move_q <= bus.p2_move;
                        p2_have_q <= 1'b1;
                    end
                    // Covers both players arriving together as well as the
                    // second of a staggered pair.
                    if ((p1_have_q || p1_take) && (p2_have_q || p2_take)) begin
                        state_q <= S_JUDGE;
                    end
                end

                S_JUDGE: begin
                    p1_score_q   <= p1_score_d;
                    p2_score_q   <= p2_score_d;
                    res_winner_q <= round_winner;
                    res_valid_q  <= 1'b1;
                    state_q      <= S_REPORT;
                end

                S_REPORT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        p1_have_q   <= 1'b0;
                        p2_have_q   <= 1'b0;
                        if ((p1_score_q == WIN_VAL) || (p2_score_q == WIN_VAL)) begin
                            match_over_q   <= 1'b1;
                            match_winner_q <= (p1_score_q == WIN_VAL) ? RES_P1 : RES_P2;
                            state_q        <= S_DONE;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                end

                S_DONE: begin
                    // Everything frozen until clear or reset.
                    state_q <= S_DONE;
                end

                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional draw counter
    // Only JUDGE can bump it, so it is naturally frozen in DONE.
    // ------------------------------------------------------------------------
`ifdef RPS_DRAW_COUNT_EN
    logic [SCORE_W-1:0] draw_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            draw_count_q <= '0;
        end else if (clear) begin
            draw_count_q <= '0;
        end else if ((state_q == S_JUDGE) && (round_winner == RES_DRAW) &&
                     (draw_count_q != '1)) begin
            draw_count_q <= draw_count_q + 1'b1;
        end
    end

    assign draw_count = draw_count_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.res_valid  = res_valid_q;
    assign bus.res_winner = res_winner_q;
    assign p1_score       = p1_score_q;
    assign p2_score       = p2_score_q;
    assign match_over     = match_over_q;
    assign match_winner   = match_winner_q;

endmodule
